// File: rtl/fifo_dest_pkg.sv
// Shared definitions for the routing-FIFO drain reader: FSM encoding and the
// position of the destination field inside a FIFO word.
package fifo_dest_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        SEND  = 2'd3
    } state_t;

    localparam int DEST_MSB = 9;
    localparam int DEST_LSB = 8;
    localparam int DEST_W   = DEST_MSB - DEST_LSB + 1;
    localparam int N_DEST   = 2 ** DEST_W;

endpackage

// File: rtl/dest_counter_bank.sv
// Debug counters: one wrapping delivery counter per lane plus a stall counter
// that saturates so a long backpressure episode never reads back as small.
module dest_counter_bank
    import fifo_dest_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_DEST-1:0]       inc_lane,
    input  logic                    stall,
    output logic [N_DEST*CNT_W-1:0] counts,
    output logic [CNT_W-1:0]        stall_count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counts      <= '0;
            stall_count <= '0;
        end else begin
            for (int i = 0; i < N_DEST; i++) begin
                if (inc_lane[i]) begin
                    counts[i*CNT_W +: CNT_W] <= counts[i*CNT_W +: CNT_W] + 1'b1;
                end
            end
            if (stall && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_dest_reader.sv
// Drains the routing FIFO one word at a time and pushes each word to the
// destination FIFO selected by its destination field, honouring per-lane backpressure.
module fifo_dest_reader
    import fifo_dest_pkg::*;
#(
    parameter int WORD_SIZE = 10,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    fifo_empty,
    input  logic [WORD_SIZE-1:0]    fifo_data_out,
    output logic                    fifo_rd,
    input  logic [N_DEST-1:0]       out_almost_full,
    output logic [N_DEST-1:0]       out_push,
    output logic [WORD_SIZE-1:0]    out_data,
    output logic                    busy,
    output logic [N_DEST*CNT_W-1:0] dest_count,
    output logic [CNT_W-1:0]        stall_count
);

    state_t                 state;
    state_t                 next_state;
    logic [WORD_SIZE-1:0]   hold_reg;
    logic [DEST_W-1:0]      dest;
    logic                   blocked;
    logic                   stall;

    assign dest    = hold_reg[DEST_MSB:DEST_LSB];
    assign blocked = out_almost_full[dest];

    // Source read data arrives the cycle after the pop, so it is captured in LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            hold_reg <= '0;
        end else begin
            state <= next_state;
            if (state == LOAD) begin
                hold_reg <= fifo_data_out;
            end
        end
    end

    always_comb begin
        next_state = state;
        fifo_rd    = 1'b0;
        out_push   = '0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                fifo_rd    = 1'b1;
                next_state = LOAD;
            end
            LOAD: begin
                next_state = SEND;
            end
            SEND: begin
                // Push is combinational on the flag so a release is seen in the same cycle.
                if (blocked) begin
                    stall = 1'b1;
                end else begin
                    out_push[dest] = 1'b1;
                    next_state     = (enable && !fifo_empty) ? FETCH : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign out_data = hold_reg;
    assign busy     = (state != IDLE);

    dest_counter_bank #(
        .CNT_W(CNT_W)
    ) u_counters (
        .clk        (clk),
        .reset      (reset),
        .inc_lane   (out_push),
        .stall      (stall),
        .counts     (dest_count),
        .stall_count(stall_count)
    );

endmodule

// File: tb/tb_fifo_dest_reader.sv
// Scoreboard bench for fifo_dest_reader: a behavioural source FIFO feeds words,
// each loaded word is queued as expected output and matched against every push.
module tb_fifo_dest_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        fifo_empty;
    logic [9:0]  fifo_data_out = '0;
    logic        fifo_rd;
    logic [3:0]  out_almost_full;
    logic [3:0]  out_push;
    logic [9:0]  out_data;
    logic        busy;
    logic [31:0] dest_count;
    logic [7:0]  stall_count;

    logic [9:0]  mem [512];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [9:0]  sb [$];
    int          push_cyc [$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fifo_dest_reader dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd        (fifo_rd),
        .out_almost_full(out_almost_full),
        .out_push       (out_push),
        .out_data       (out_data),
        .busy           (busy),
        .dest_count     (dest_count),
        .stall_count    (stall_count)
    );

    // Source FIFO model: read data is registered one cycle after the pop.
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd) begin
            fifo_data_out <= mem[rd_ptr % 512];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #3;
        if (reset && (out_push != 4'b0)) begin
            if (sb.size() == 0) begin
                chk("unexpected_push", {28'b0, out_push}, 32'b0);
            end else begin
                logic [9:0] w;
                w = sb.pop_front();
                chk("push_lane", {28'b0, out_push}, 32'(4'b0001 << w[9:8]));
                chk("push_data", {22'b0, out_data}, {22'b0, w});
                push_cyc.push_back(cyc);
            end
        end
    end

    task automatic load(input logic [9:0] w);
        mem[wr_ptr % 512] = w;
        wr_ptr++;
        sb.push_back(w);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b0;
        enable          = 1'b1;
        out_almost_full = 4'b0;
        wr_ptr          = rd_ptr;
        sb.delete();
        push_cyc.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_rd(input string tag);
        int k;
        k = 0;
        while (!fifo_rd && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tag, {31'b0, fifo_rd}, 32'd1);
    endtask

    task automatic wait_drain(input string tag, input int max);
        int k;
        k = 0;
        while (k < max) begin
            @(negedge clk);
            #4;
            if (sb.size() == 0 && !busy) break;
            k++;
        end
        chk(tag, sb.size(), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b0;
        enable          = 1'b1;
        out_almost_full = 4'b0;
        load(10'h2A5);

        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_fifo_rd", {31'b0, fifo_rd}, 32'd0);
            chk("rst_push", {28'b0, out_push}, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_counts", dest_count, 32'd0);
            chk("rst_stall", {24'b0, stall_count}, 32'd0);
            chk("rst_data", {22'b0, out_data}, 32'd0);
        end

        // Single word: FETCH on the first edge after release, push two cycles later.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("first_fetch", {31'b0, fifo_rd}, 32'd1);
        @(negedge clk); #1;
        chk("load_no_push", {28'b0, out_push}, 32'd0);
        chk("load_no_rd", {31'b0, fifo_rd}, 32'd0);
        @(negedge clk); #1;
        chk("single_push", {28'b0, out_push}, 32'h4);
        chk("single_data", {22'b0, out_data}, 32'h2A5);
        @(negedge clk); #1;
        chk("single_idle", {31'b0, busy}, 32'd0);
        chk("single_lane2", {24'b0, dest_count[23:16]}, 32'd1);

        // Four-word stream across all lanes.
        do_reset();
        load(10'h011);
        load(10'h122);
        load(10'h233);
        load(10'h344);
        wait_drain("stream_drain", 100);
        chk("stream_npush", push_cyc.size(), 32'd4);
        if (push_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                chk("stream_gap", push_cyc[i] - push_cyc[i-1], 32'd3);
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk("stream_lane_cnt", {24'b0, dest_count[i*8 +: 8]}, 32'd1);
        end

        // Backpressure on lane 1 for five cycles, second word waiting behind it.
        do_reset();
        out_almost_full = 4'b0010;
        load(10'h1FF);
        load(10'h0C3);
        wait_rd("bp_fetch");
        @(negedge clk);
        @(negedge clk); #1;
        chk("bp_first_block", {28'b0, out_push}, 32'd0);
        chk("bp_stall0", {24'b0, stall_count}, 32'd0);
        repeat (5) begin
            @(negedge clk); #1;
            chk("bp_no_rd", {31'b0, fifo_rd}, 32'd0);
            chk("bp_no_push", {28'b0, out_push}, 32'd0);
        end
        chk("bp_stall5", {24'b0, stall_count}, 32'd5);
        out_almost_full = 4'b0;
        #1;
        chk("bp_release_push", {28'b0, out_push}, 32'h2);
        wait_drain("bp_drain", 50);
        chk("bp_lane1", {24'b0, dest_count[15:8]}, 32'd1);
        chk("bp_lane0", {24'b0, dest_count[7:0]}, 32'd1);
        chk("bp_stall_hold", {24'b0, stall_count}, 32'd5);

        // Enable dropped during LOAD: held word still delivered, then idle.
        do_reset();
        load(10'h2B1);
        load(10'h0D2);
        wait_rd("ed_fetch");
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk); #1;
        chk("ed_push", {28'b0, out_push}, 32'h4);
        repeat (6) begin
            @(negedge clk); #1;
            chk("ed_no_rd", {31'b0, fifo_rd}, 32'd0);
            chk("ed_idle", {31'b0, busy}, 32'd0);
        end
        enable = 1'b1;
        wait_drain("ed_drain", 50);
        chk("ed_lane2", {24'b0, dest_count[23:16]}, 32'd1);
        chk("ed_lane0", {24'b0, dest_count[7:0]}, 32'd1);

        // 256 deliveries to lane 3 wrap its counter.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            load({2'b11, 8'(i)});
        end
        wait_drain("wrap_drain", 1000);
        chk("wrap_lane3", {24'b0, dest_count[31:24]}, 32'd0);
        chk("wrap_other", {8'b0, dest_count[23:0]}, 32'd0);
        load(10'h300);
        wait_drain("wrap_drain2", 50);
        chk("wrap_lane3_next", {24'b0, dest_count[31:24]}, 32'd1);

        // 300 blocked cycles saturate the stall counter.
        do_reset();
        out_almost_full = 4'b1000;
        load(10'h3AA);
        wait_rd("sat_fetch");
        @(negedge clk);
        @(negedge clk);
        repeat (200) @(negedge clk);
        #1;
        chk("sat_200", {24'b0, stall_count}, 32'd200);
        repeat (100) @(negedge clk);
        #1;
        chk("sat_255", {24'b0, stall_count}, 32'd255);
        out_almost_full = 4'b0;
        wait_drain("sat_drain", 50);
        chk("sat_lane3", {24'b0, dest_count[31:24]}, 32'd1);
        chk("sat_hold", {24'b0, stall_count}, 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
